// File: rtl/can_tx_scheduler_pkg.sv
// Shared widths and scheduler state encoding for the CAN transmit mailbox scheduler.
package can_tx_scheduler_pkg;

    localparam int CAN_ID_W   = 11;
    localparam int CAN_DATA_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_START  = 3'd2,
        ST_BUSY   = 3'd3,
        ST_GAP    = 3'd4
    } sched_state_e;

endpackage

// File: rtl/can_tx_scheduler_prio_sel.sv
// Lowest-ID arbiter over the pending mailboxes; a binary compare tree where the
// left (lower-index) branch wins ties, so equal IDs resolve to the lower mailbox.
module can_tx_scheduler_prio_sel
    import can_tx_scheduler_pkg::*;
#(
    parameter int NUM_MB = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_MB-1:0]               pending,
    input  logic [NUM_MB-1:0][CAN_ID_W-1:0] ids,
    output logic [IDX_W-1:0]                sel_idx,
    output logic                            valid
);

    localparam int LEAVES = 1 << $clog2(NUM_MB);
    localparam int NODES  = 2 * LEAVES - 1;

    logic                nv  [NODES];
    logic [CAN_ID_W-1:0] nid [NODES];
    logic [IDX_W-1:0]    nix [NODES];

    // Heap layout: node n has children 2n+1 (lower indices) and 2n+2.
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            nv[n]  = 1'b0;
            nid[n] = '0;
            nix[n] = '0;
        end
        for (int i = 0; i < NUM_MB; i++) begin
            nv[LEAVES-1+i]  = pending[i];
            nid[LEAVES-1+i] = ids[i];
            nix[LEAVES-1+i] = IDX_W'(i);
        end
        for (int n = LEAVES - 2; n >= 0; n--) begin
            if (nv[2*n+1] && (!nv[2*n+2] || (nid[2*n+1] <= nid[2*n+2]))) begin
                nid[n] = nid[2*n+1];
                nix[n] = nix[2*n+1];
            end else begin
                nid[n] = nid[2*n+2];
                nix[n] = nix[2*n+2];
            end
            nv[n] = nv[2*n+1] | nv[2*n+2];
        end
        sel_idx = nix[0];
        valid   = nv[0];
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Transmit mailbox scheduler: holds NUM_MB frames, hands the lowest-ID pending
// frame to tx_block, and reports completion, start timeout and rejected writes.
module can_tx_scheduler
    import can_tx_scheduler_pkg::*;
#(
    parameter int NUM_MB   = 4,
    parameter int START_TO = 4096,
    parameter int GAP_CYC  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_idx,
    input  logic [CAN_ID_W-1:0]   wr_id,
    input  logic [CAN_DATA_W-1:0] wr_data,
    input  logic                  abort_en,
    input  logic [2:0]            abort_idx,
    input  logic                  txing,
    output logic                  tx_start,
    output logic [CAN_ID_W-1:0]   address_tx,
    output logic [CAN_DATA_W-1:0] tx_data,
    output logic [NUM_MB-1:0]     pending,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            done_idx,
    output logic                  wr_err,
    output logic                  to_err
);

    localparam int IDX_W   = $clog2(NUM_MB);
    localparam int SLOTS   = 1 << IDX_W;
    localparam int TMR_MAX = (START_TO > GAP_CYC) ? START_TO : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    // Marks which decoded slot numbers map onto a real mailbox.
    localparam logic [SLOTS-1:0] SLOT_MASK = SLOTS'({SLOTS{1'b1}} >> (SLOTS - NUM_MB));

    logic [NUM_MB-1:0][CAN_ID_W-1:0]   mb_id;
    logic [NUM_MB-1:0][CAN_DATA_W-1:0] mb_data;

    sched_state_e        state, state_nxt;
    logic [TMR_W-1:0]    timer;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    sel_cand;
    logic                sel_valid;
    logic [NUM_MB-1:0]   pending_nxt;

    logic [IDX_W-1:0]    wr_slot, abort_slot;
    logic                in_flight;
    logic                wr_hit_flight, wr_accept, abort_ok;
    logic                sel_load, frame_done, frame_to;
    logic                unused_idx_bits;

    assign wr_slot    = wr_idx[IDX_W-1:0];
    assign abort_slot = abort_idx[IDX_W-1:0];
    assign unused_idx_bits = ^{wr_idx, abort_idx};

    // The selected mailbox is locked against writes/aborts only while tx_block may be using it.
    assign in_flight     = (state == ST_START) || (state == ST_BUSY);
    assign wr_hit_flight = wr_en && in_flight && (wr_slot == sel_idx);
    assign wr_accept     = wr_en && SLOT_MASK[wr_slot] && !wr_hit_flight;
    assign abort_ok      = abort_en && SLOT_MASK[abort_slot] &&
                           !(in_flight && (abort_slot == sel_idx));

    assign busy = (state != ST_IDLE);

    can_tx_scheduler_prio_sel #(
        .NUM_MB (NUM_MB),
        .IDX_W  (IDX_W)
    ) u_prio_sel (
        .pending (pending),
        .ids     (mb_id),
        .sel_idx (sel_cand),
        .valid   (sel_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_load   = 1'b0;
        frame_done = 1'b0;
        frame_to   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|pending) state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                if (sel_valid) begin
                    state_nxt = ST_START;
                    sel_load  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (txing) begin
                    state_nxt = ST_BUSY;
                end else if (timer == TMR_W'(START_TO - 1)) begin
                    state_nxt = ST_GAP;
                    frame_to  = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!txing) begin
                    state_nxt  = ST_GAP;
                    frame_done = 1'b1;
                end
            end
            ST_GAP: begin
                if (timer == TMR_W'(GAP_CYC - 1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write wins over abort on the same mailbox; completion clears the sent one.
    always_comb begin
        pending_nxt = pending;
        if (abort_ok)   pending_nxt[abort_slot] = 1'b0;
        if (wr_accept)  pending_nxt[wr_slot]    = 1'b1;
        if (frame_done) pending_nxt[sel_idx]    = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else if ((state == ST_START) || (state == ST_GAP)) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending    <= '0;
            sel_idx    <= '0;
            tx_start   <= 1'b0;
            address_tx <= '0;
            tx_data    <= '0;
            done       <= 1'b0;
            done_idx   <= '0;
            wr_err     <= 1'b0;
            to_err     <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            tx_start <= (state_nxt == ST_START);
            done     <= frame_done;
            to_err   <= frame_to;
            wr_err   <= wr_hit_flight;
            if (frame_done || frame_to) done_idx <= 3'(sel_idx);
            if (sel_load) begin
                sel_idx    <= sel_cand;
                address_tx <= mb_id[sel_cand];
                tx_data    <= mb_data[sel_cand];
            end
        end
    end

    // Frame storage survives reset; only the pending flags decide what is live.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mb_id[wr_slot]   <= wr_id;
            mb_data[wr_slot] <= wr_data;
        end
    end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a transaction-level mailbox model.
`timescale 1ns/1ps
module tb_can_tx_scheduler;

    localparam int NUM_MB   = 4;
    localparam int START_TO = 64;
    localparam int GAP_CYC  = 16;

    localparam int P_IDLE = 0, P_SELECT = 1, P_START = 2, P_BUSY = 3, P_GAP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [10:0] wr_id;
    logic [63:0] wr_data;
    logic        abort_en;
    logic [2:0]  abort_idx;
    logic        txing;
    logic        tx_start;
    logic [10:0] address_tx;
    logic [63:0] tx_data;
    logic [NUM_MB-1:0] pending;
    logic        busy;
    logic        done;
    logic [2:0]  done_idx;
    logic        wr_err;
    logic        to_err;

    always #5 clk = ~clk;

    can_tx_scheduler #(
        .NUM_MB   (NUM_MB),
        .START_TO (START_TO),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_id      (wr_id),
        .wr_data    (wr_data),
        .abort_en   (abort_en),
        .abort_idx  (abort_idx),
        .txing      (txing),
        .tx_start   (tx_start),
        .address_tx (address_tx),
        .tx_data    (tx_data),
        .pending    (pending),
        .busy       (busy),
        .done       (done),
        .done_idx   (done_idx),
        .wr_err     (wr_err),
        .to_err     (to_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mailbox contents, pending set, transmission phase and
    // the number of cycles spent in the current phase.
    logic [10:0] m_id   [NUM_MB];
    logic [63:0] m_data [NUM_MB];
    bit          m_pend [NUM_MB];
    int          m_phase = P_IDLE;
    int          m_cnt   = 0;
    int          m_sel   = 0;
    logic        e_start = 0, e_done = 0, e_wrerr = 0, e_toerr = 0;
    logic [10:0] e_addr  = 0;
    logic [63:0] e_data  = 0;
    int          e_didx  = 0;

    int          start_cnt  = 0;
    logic        prev_start = 0;
    logic [10:0] start_addr_q [$];
    int          done_q [$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_step();
        int  best;
        int  ws, as;
        bit  in_flight;
        bit  clear_sel;
        e_done    = 0;
        e_wrerr   = 0;
        e_toerr   = 0;
        clear_sel = 0;
        if (!rst) begin
            m_phase = P_IDLE;
            m_cnt   = 0;
            for (int i = 0; i < NUM_MB; i++) m_pend[i] = 0;
            e_start = 0;
            e_addr  = 0;
            e_data  = 0;
            e_didx  = 0;
            return;
        end
        in_flight = (m_phase == P_START) || (m_phase == P_BUSY);
        best = -1;
        for (int i = 0; i < NUM_MB; i++)
            if (m_pend[i] && (best < 0 || m_id[i] < m_id[best])) best = i;
        ws = int'(wr_idx) % NUM_MB;
        as = int'(abort_idx) % NUM_MB;
        case (m_phase)
            P_IDLE:   if (best >= 0) m_phase = P_SELECT;
            P_SELECT: begin
                if (best < 0) m_phase = P_IDLE;
                else begin
                    m_sel   = best;
                    e_addr  = m_id[best];
                    e_data  = m_data[best];
                    m_phase = P_START;
                    m_cnt   = 0;
                end
            end
            P_START: begin
                m_cnt++;
                if (txing) m_phase = P_BUSY;
                else if (m_cnt == START_TO) begin
                    e_toerr = 1;
                    e_didx  = m_sel;
                    m_phase = P_GAP;
                    m_cnt   = 0;
                end
            end
            P_BUSY: begin
                if (!txing) begin
                    e_done    = 1;
                    e_didx    = m_sel;
                    clear_sel = 1;
                    m_phase   = P_GAP;
                    m_cnt     = 0;
                end
            end
            default: begin
                m_cnt++;
                if (m_cnt == GAP_CYC) m_phase = P_IDLE;
            end
        endcase
        if (abort_en && !(in_flight && as == m_sel)) m_pend[as] = 0;
        if (wr_en) begin
            if (in_flight && ws == m_sel) e_wrerr = 1;
            else begin
                m_id[ws]   = wr_id;
                m_data[ws] = wr_data;
                m_pend[ws] = 1;
            end
        end
        if (clear_sel) m_pend[m_sel] = 0;
        e_start = (m_phase == P_START);
    endtask

    task automatic compare_all();
        logic [NUM_MB-1:0] mp;
        for (int i = 0; i < NUM_MB; i++) mp[i] = m_pend[i];
        chk("tx_start",   tx_start,   e_start);
        chk("address_tx", address_tx, e_addr);
        chk("tx_data",    tx_data,    e_data);
        chk("pending",    pending,    mp);
        chk("busy",       busy,       (m_phase != P_IDLE));
        chk("done",       done,       e_done);
        chk("done_idx",   done_idx,   64'(e_didx));
        chk("wr_err",     wr_err,     e_wrerr);
        chk("to_err",     to_err,     e_toerr);
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_step();
        #1;
        compare_all();
        if (tx_start && !prev_start) start_addr_q.push_back(address_tx);
        if (tx_start) start_cnt++;
        if (done) done_q.push_back(int'(done_idx));
        prev_start = tx_start;
    endtask

    task automatic load(int idx, logic [10:0] id, logic [63:0] d);
        wr_en   = 1'b1;
        wr_idx  = 3'(idx);
        wr_id   = id;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_start(int bound);
        int n = 0;
        while (!tx_start && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (!tx_start) begin
            errors++;
            $display("FAIL wait_start: tx_start low after %0d cycles, expected high", bound);
        end
    endtask

    task automatic wait_idle(int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", bound);
        end
    endtask

    // tx_start is high in the current cycle; txing rises d cycles into the
    // request, stays up for len edges, then falls.
    task automatic finish_frame(int d, int len);
        repeat (d - 1) tick();
        txing = 1'b1;
        repeat (len) tick();
        txing = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int td;
        int tl;
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_id     = '0;
        wr_data   = '0;
        abort_en  = 1'b0;
        abort_idx = '0;
        txing     = 1'b0;
        repeat (3) tick();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_pending",  pending,  0);
        chk("rst_busy",     busy,     0);
        chk("rst_addr",     address_tx, 0);
        chk("rst_done_idx", done_idx, 0);
        rst = 1'b1;
        tick();

        // lower ID wins regardless of mailbox order
        start_addr_q.delete();
        done_q.delete();
        load(0, 11'h123, 64'hA0A0_0000_0000_0123);
        load(1, 11'h050, 64'hA1A1_0000_0000_0050);
        wait_start(10);
        finish_frame(3, 10);
        wait_start(40);
        finish_frame(3, 10);
        chk("t1_nstarts", start_addr_q.size(), 2);
        chk("t1_addr0", (start_addr_q.size() > 0) ? start_addr_q[0] : 11'h7FF, 11'h050);
        chk("t1_addr1", (start_addr_q.size() > 1) ? start_addr_q[1] : 11'h7FF, 11'h123);
        chk("t1_ndone", done_q.size(), 2);
        chk("t1_done0", (done_q.size() > 0) ? done_q[0] : 99, 1);
        chk("t1_done1", (done_q.size() > 1) ? done_q[1] : 99, 0);

        // 3-cycle latency and tx_start held until txing rises
        wait_idle(40);
        start_cnt = 0;
        load(2, 11'h100, 64'h0123_4567_89AB_CDEF);
        tick();
        chk("t2_lat2", tx_start, 0);
        tick();
        chk("t2_lat3", tx_start, 1);
        finish_frame(5, 100);
        chk("t2_start_len", start_cnt, 5);
        chk("t2_done", done, 1);
        chk("t2_done_idx", done_idx, 2);
        chk("t2_pending", pending, 0);
        chk("t2_data", tx_data, 64'h0123_4567_89AB_CDEF);
        tick();
        chk("t2_done_pulse", done, 0);

        // start timeout, mailbox kept and retried after the gap
        wait_idle(40);
        start_cnt = 0;
        load(3, 11'h300, 64'h3333);
        wait_start(10);
        n = 0;
        while (!to_err && n < 100) begin
            tick();
            n++;
        end
        chk("t3_to_err", to_err, 1);
        chk("t3_start_len", start_cnt, START_TO);
        chk("t3_idx", done_idx, 3);
        chk("t3_pending", pending[3], 1);
        n = 0;
        while (!tx_start && n < 40) begin
            tick();
            n++;
        end
        chk("t3_retry_gap", n, GAP_CYC + 2);
        finish_frame(2, 5);
        chk("t3_done_idx", done_idx, 3);

        // in-flight protection during BUSY
        wait_idle(40);
        load(1, 11'h010, 64'hD1D1);
        load(3, 11'h400, 64'hD3D3);
        wait_start(10);
        chk("t4_addr", address_tx, 11'h010);
        txing = 1'b1;
        tick();
        wr_en = 1'b1; wr_idx = 3'd1; wr_id = 11'h7FF; wr_data = 64'hBAD;
        tick();
        wr_en = 1'b0;
        chk("t4_wr_err", wr_err, 1);
        abort_en = 1'b1; abort_idx = 3'd1;
        tick();
        chk("t4_abort_inflight", pending, 4'b1010);
        abort_idx = 3'd3;
        tick();
        abort_en = 1'b0;
        chk("t4_abort3", pending, 4'b0010);
        chk("t4_addr_hold", address_tx, 11'h010);
        chk("t4_data_hold", tx_data, 64'hD1D1);
        txing = 1'b0;
        tick();
        chk("t4_done_idx", done_idx, 1);
        chk("t4_pending", pending, 0);
        start_cnt = 0;
        repeat (40) tick();
        chk("t4_no_start", start_cnt, 0);

        // equal IDs resolve to the lower mailbox
        load(3, 11'h200, 64'h3030);
        load(0, 11'h200, 64'h0000_0303);
        done_q.delete();
        wait_start(10);
        chk("t5_data", tx_data, 64'h0000_0303);
        finish_frame(2, 4);
        wait_start(40);
        finish_frame(2, 4);
        chk("t5_done0", (done_q.size() > 0) ? done_q[0] : 99, 0);
        chk("t5_done1", (done_q.size() > 1) ? done_q[1] : 99, 3);

        // reset in the middle of a frame
        wait_idle(40);
        load(2, 11'h111, 64'h2222);
        wait_start(10);
        txing = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t6_tx_start", tx_start, 0);
        chk("t6_pending", pending, 0);
        chk("t6_busy", busy, 0);
        rst = 1'b1;
        txing = 1'b0;
        tick();
        done_q.delete();
        load(1, 11'h022, 64'h1111);
        wait_start(10);
        finish_frame(3, 8);
        chk("t6_ndone", done_q.size(), 1);
        chk("t6_done_idx", (done_q.size() > 0) ? done_q[0] : 99, 1);

        // randomized traffic with a reactive tx_block
        td = -1;
        tl = 0;
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 799) != 0);
            wr_en     = ($urandom_range(0, 9) == 0);
            wr_idx    = 3'($urandom_range(0, 7));
            wr_id     = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 7)) : 11'($urandom);
            wr_data   = {$urandom, $urandom};
            abort_en  = ($urandom_range(0, 19) == 0);
            abort_idx = 3'($urandom_range(0, 7));
            if (txing) begin
                tl--;
                if (tl <= 0) txing = 1'b0;
            end else if (tx_start) begin
                if (td < 0) td = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 6);
                if (td == 0) begin
                    txing = 1'b1;
                    tl    = $urandom_range(1, 20);
                    td    = -1;
                end else begin
                    td--;
                end
            end else begin
                td = -1;
            end
            tick();
        end
        rst      = 1'b1;
        wr_en    = 1'b0;
        abort_en = 1'b0;
        txing    = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
